dbus_arbiter: RTL and testbench



---
 rtl/dbus_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_dbus_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dbus_arbiter
//
// Two-master to one-slave data-bus arbiter. m0 is the core memory stage, m1
// is a debug/DMA master. One transaction is in flight at a time. The FSM
// moves through IDLE -> XFER -> RESP, and a round-robin priority bit decides
// the winner when both masters request in the same cycle.
//
// Optional feature (compile-time macro DBUS_TIMEOUT_EN):
//   When defined, an XFER that sees no s_ack_i for TIMEOUT_CYCLES cycles is
//   aborted. The aborted transaction completes with rvalid, err_o = 1 and
//   m_rdata_o = 0. When undefined, XFER waits indefinitely for the ack,
//   there is no counter, and err_o is tied to 0.
//
// Ports
//   clk_i                 clock, all state on the rising edge
//   n_rst_i               asynchronous active-low reset
//   m{0,1}_req_i          access request
//   m{0,1}_we_i           1 = store, 0 = load
//   m{0,1}_addr_i [31:0]  byte address
//   m{0,1}_wdata_i[31:0]  store data
//   m{0,1}_sel_i  [3:0]   byte enables
//   m{0,1}_gnt_o          one-cycle pulse: request accepted and latched
//   m{0,1}_rvalid_o       one-cycle pulse: transaction complete
//   m_rdata_o     [31:0]  load data (0 for stores), valid with rvalid
//   err_o                 timeout abort flag, valid with rvalid
//   s_req_o, s_we_o       slave request / write enable
//   s_addr_o, s_wdata_o   latched address / store data
//   s_sel_o       [3:0]   latched byte enables
//   s_ack_i               slave completion (s_rdata_i valid in that cycle)
//   s_rdata_i     [31:0]  slave read data
//   stall_req_o           pipeline stall request for m0 (combinational)
// -----------------------------------------------------------------------------
module dbus_arbiter
`ifdef DBUS_TIMEOUT_EN
  #(
    parameter int unsigned TIMEOUT_CYCLES = 16
  )
`endif
  (
    input  logic        clk_i,
    input  logic        n_rst_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [3:0]  m0_sel_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [3:0]  m1_sel_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,

    output logic [31:0] m_rdata_o,
    output logic        err_o,

    output logic        s_req_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    output logic [3:0]  s_sel_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_rdata_i,

    output logic        stall_req_o
  );

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_prio;     // 0: m0 preferred on a tie, 1: m1 preferred
  logic        r_owner;    // 0: m0 owns the transaction, 1: m1
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_sel;
  logic        r_sreq;
  logic        r_gnt0;
  logic        r_gnt1;
  logic        r_rv0;
  logic        r_rv1;
  logic [31:0] r_rdata;

`ifdef DBUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;  // current transaction was aborted
  logic             r_err;
`endif

  // Winner selection: the priority bit only matters when both request.
  logic        w_any_req;
  logic        w_win_m1;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_sel;

  assign w_any_req = m0_req_i | m1_req_i;
  assign w_win_m1  = (m0_req_i & m1_req_i) ? r_prio : m1_req_i;
  assign w_we      = w_win_m1 ? m1_we_i    : m0_we_i;
  assign w_addr    = w_win_m1 ? m1_addr_i  : m0_addr_i;
  assign w_wdata   = w_win_m1 ? m1_wdata_i : m0_wdata_i;
  assign w_sel     = w_win_m1 ? m1_sel_i   : m0_sel_i;

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_state   <= IDLE;
      r_prio    <= 1'b0;
      r_owner   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      r_sel     <= 4'h0;
      r_sreq    <= 1'b0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rv0     <= 1'b0;
      r_rv1     <= 1'b0;
      r_rdata   <= 32'h0;
`ifdef DBUS_TIMEOUT_EN
      r_cnt     <= '0;
      r_timeout <= 1'b0;
      r_err     <= 1'b0;
`endif
    end else begin
      // Pulses default low; each is raised for exactly one cycle below.
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_rv0  <= 1'b0;
      r_rv1  <= 1'b0;
`ifdef DBUS_TIMEOUT_EN
      r_err  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner <= w_win_m1;
            r_prio  <= ~w_win_m1;  // next tie goes to the master that lost
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_sel   <= w_sel;
            r_gnt0  <= ~w_win_m1;
            r_gnt1  <= w_win_m1;
            r_sreq  <= 1'b1;
            r_state <= XFER;
`ifdef DBUS_TIMEOUT_EN
            r_cnt     <= '0;
            r_timeout <= 1'b0;
`endif
          end
        end

        XFER: begin
          if (s_ack_i) begin
            r_sreq  <= 1'b0;
            r_rdata <= r_we ? 32'h0 : s_rdata_i;
            r_state <= RESP;
          end
`ifdef DBUS_TIMEOUT_EN
          // The count equals the number of completed unacked XFER cycles;
          // the last allowed cycle is reached at TIMEOUT_CYCLES-1.
          else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_sreq    <= 1'b0;
            r_rdata   <= 32'h0;
            r_timeout <= 1'b1;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end

        RESP: begin
          r_rv0   <= ~r_owner;
          r_rv1   <= r_owner;
`ifdef DBUS_TIMEOUT_EN
          r_err   <= r_timeout;
`endif
          r_state <= IDLE;
        end

        default: begin
          r_sreq  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign m0_gnt_o    = r_gnt0;
  assign m1_gnt_o    = r_gnt1;
  assign m0_rvalid_o = r_rv0;
  assign m1_rvalid_o = r_rv1;
  assign m_rdata_o   = r_rdata;

`ifdef DBUS_TIMEOUT_EN
  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  assign s_req_o   = r_sreq;
  assign s_we_o    = r_we;
  assign s_addr_o  = r_addr;
  assign s_wdata_o = r_wdata;
  assign s_sel_o   = r_sel;

  // Gated by reset so every output reads 0 while reset is held, even if
  // the core keeps its request up.
  assign stall_req_o = n_rst_i & m0_req_i & ~r_rv0;

endmodule

// File: tb/tb_dbus_arbiter.sv
`timescale 1ns/1ps
module tb_dbus_arbiter;

  logic        clk_i = 1'b0;
  logic        n_rst_i = 1'b0;
  logic        m0_req_i = 1'b0, m0_we_i = 1'b0;
  logic [31:0] m0_addr_i = 32'h0, m0_wdata_i = 32'h0;
  logic [3:0]  m0_sel_i = 4'h0;
  logic        m1_req_i = 1'b0, m1_we_i = 1'b0;
  logic [31:0] m1_addr_i = 32'h0, m1_wdata_i = 32'h0;
  logic [3:0]  m1_sel_i = 4'h0;
  logic        s_ack_i = 1'b0;
  logic [31:0] s_rdata_i = 32'h0;

  logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
  logic [31:0] m_rdata_o;
  logic        err_o;
  logic        s_req_o, s_we_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic [3:0]  s_sel_o;
  logic        stall_req_o;

  int n_tests = 0;
  int n_fail = 0;
  int excl_viol = 0;

  // slave model controls
  int          ack_delay = 0;
  int          sl_cnt = 0;
  logic [31:0] sl_rdata = 32'h0;

  dbus_arbiter dut (
    .clk_i(clk_i), .n_rst_i(n_rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_wdata_i(m0_wdata_i), .m0_sel_i(m0_sel_i),
    .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i), .m1_sel_i(m1_sel_i),
    .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
    .m_rdata_o(m_rdata_o), .err_o(err_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_wdata_o(s_wdata_o), .s_sel_o(s_sel_o),
    .s_ack_i(s_ack_i), .s_rdata_i(s_rdata_i),
    .stall_req_o(stall_req_o)
  );

  always #5 clk_i = ~clk_i;

  // Slave: acks once s_req_o has been seen for ack_delay earlier cycles.
  always @(negedge clk_i) begin
    if (s_req_o) begin
      if (sl_cnt >= ack_delay) begin
        s_ack_i   = 1'b1;
        s_rdata_i = sl_rdata;
      end else begin
        s_ack_i   = 1'b0;
        s_rdata_i = 32'hBAD0BAD0;
      end
      sl_cnt++;
    end else begin
      s_ack_i = 1'b0;
      sl_cnt  = 0;
    end
  end

  // Mutual exclusion of gnt / rvalid between the masters.
  always @(negedge clk_i) begin
    if ((m0_gnt_o && m1_gnt_o) || (m0_rvalid_o && m1_rvalid_o)) excl_viol++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %h", name, act);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic clear_masters();
    m0_req_i = 1'b0; m0_we_i = 1'b0; m0_addr_i = 32'h0; m0_wdata_i = 32'h0; m0_sel_i = 4'h0;
    m1_req_i = 1'b0; m1_we_i = 1'b0; m1_addr_i = 32'h0; m1_wdata_i = 32'h0; m1_sel_i = 4'h0;
  endtask

  task automatic do_reset(input bit check);
    clear_masters();
    ack_delay = 0;
    m0_req_i  = 1'b1;  // outputs must still read 0 during reset
    n_rst_i   = 1'b0;
    tick();
    tick();
    if (check) begin
      chk("rst_s_req", {31'h0, s_req_o}, 32'h0);
      chk("rst_gnt", {30'h0, m1_gnt_o, m0_gnt_o}, 32'h0);
      chk("rst_rvalid", {30'h0, m1_rvalid_o, m0_rvalid_o}, 32'h0);
      chk("rst_rdata", m_rdata_o, 32'h0);
      chk("rst_err", {31'h0, err_o}, 32'h0);
      chk("rst_stall", {31'h0, stall_req_o}, 32'h0);
    end
    m0_req_i = 1'b0;
    n_rst_i  = 1'b1;
    tick();
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m0_gnt_o || m1_gnt_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rvalid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (m0_rvalid_o || m1_rvalid_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic        m0_req, m1_req;
    logic        m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] sl_rdata;
    int          delay;
    logic [1:0]  exp_win;    // {m1, m0}
    logic        exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_sel;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v, input int idx);
    bit ok;
    m0_req_i = v.m0_req; m0_we_i = v.m0_we; m0_addr_i = v.m0_addr;
    m0_wdata_i = v.m0_wdata; m0_sel_i = v.m0_sel;
    m1_req_i = v.m1_req; m1_we_i = v.m1_we; m1_addr_i = v.m1_addr;
    m1_wdata_i = v.m1_wdata; m1_sel_i = v.m1_sel;
    ack_delay = v.delay;
    sl_rdata  = v.sl_rdata;
    wait_gnt(ok);
    chk($sformatf("v%0d_gnt_seen", idx), {31'h0, ok}, 32'h1);
    if (ok) begin
      chk($sformatf("v%0d_gnt", idx), {30'h0, m1_gnt_o, m0_gnt_o}, {30'h0, v.exp_win});
      chk($sformatf("v%0d_s_req", idx), {31'h0, s_req_o}, 32'h1);
      chk($sformatf("v%0d_s_we", idx), {31'h0, s_we_o}, {31'h0, v.exp_we});
      chk($sformatf("v%0d_s_addr", idx), s_addr_o, v.exp_addr);
      chk($sformatf("v%0d_s_wdata", idx), s_wdata_o, v.exp_wdata);
      chk($sformatf("v%0d_s_sel", idx), {28'h0, s_sel_o}, {28'h0, v.exp_sel});
      m0_req_i = 1'b0;
      m1_req_i = 1'b0;
      wait_rvalid(ok);
      chk($sformatf("v%0d_rvalid_seen", idx), {31'h0, ok}, 32'h1);
      chk($sformatf("v%0d_rvalid", idx), {30'h0, m1_rvalid_o, m0_rvalid_o}, {30'h0, v.exp_win});
      chk($sformatf("v%0d_rdata", idx), m_rdata_o, v.exp_rdata);
      chk($sformatf("v%0d_err", idx), {31'h0, err_o}, 32'h0);
    end
    clear_masters();
    tick();
  endtask

  initial begin
    bit          ok;
    int          ng, rv0, rv1, nx, nbad;
    logic        gseq[4];
    logic [31:0] rd;

    // Tie-break history: after the first directed load m0 has won, so m1
    // holds priority when v0 starts.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 32'h300, 32'h0, 32'h11223344,
                4'hF, 4'hF, 32'hFFFFFFFF, 0,
                2'b10, 1'b1, 32'h300, 32'h11223344, 4'hF, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h404, 32'h0, 32'h0,
                4'h0, 4'hC, 32'hCAFEF00D, 2,
                2'b10, 1'b0, 32'h404, 32'h0, 4'hC, 32'hCAFEF00D};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h508, 32'h50C, 32'hA5A5A5A5, 32'h0,
                4'h5, 4'hF, 32'hFFFFFFFF, 1,
                2'b01, 1'b1, 32'h508, 32'hA5A5A5A5, 4'h5, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0,
                4'hF, 4'h0, 32'h12345678, 0,
                2'b01, 1'b0, 32'hFFFFFFFC, 32'h0, 4'hF, 32'h12345678};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h20, 32'h0, 32'h0,
                4'hF, 4'h3, 32'h0BADF00D, 3,
                2'b10, 1'b0, 32'h20, 32'h0, 4'h3, 32'h0BADF00D};

    do_reset(1'b1);

    // ---- minimum-latency m0 load: gnt at 1, rvalid at 3 ----
    m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 32'h100; m0_sel_i = 4'hF;
    ack_delay = 0; sl_rdata = 32'hDEADBEEF;
    #1;
    chk("lat_c0_stall", {31'h0, stall_req_o}, 32'h1);
    chk("lat_c0_gnt", {31'h0, m0_gnt_o}, 32'h0);
    tick();
    chk("lat_c1_gnt", {30'h0, m1_gnt_o, m0_gnt_o}, 32'h1);
    chk("lat_c1_s_req", {31'h0, s_req_o}, 32'h1);
    chk("lat_c1_s_addr", s_addr_o, 32'h100);
    chk("lat_c1_stall", {31'h0, stall_req_o}, 32'h1);
    tick();
    chk("lat_c2_gnt", {31'h0, m0_gnt_o}, 32'h0);
    chk("lat_c2_s_req", {31'h0, s_req_o}, 32'h0);
    chk("lat_c2_rvalid", {31'h0, m0_rvalid_o}, 32'h0);
    chk("lat_c2_stall", {31'h0, stall_req_o}, 32'h1);
    tick();
    chk("lat_c3_rvalid", {30'h0, m1_rvalid_o, m0_rvalid_o}, 32'h1);
    chk("lat_c3_rdata", m_rdata_o, 32'hDEADBEEF);
    chk("lat_c3_err", {31'h0, err_o}, 32'h0);
    chk("lat_c3_stall", {31'h0, stall_req_o}, 32'h0);
    m0_req_i = 1'b0;
    tick();
    chk("lat_c4_rvalid", {31'h0, m0_rvalid_o}, 32'h0);
    chk("lat_c4_gnt", {31'h0, m0_gnt_o}, 32'h0);
    clear_masters();

    // ---- table-driven single transactions ----
    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // ---- round robin with both requests held from reset ----
    do_reset(1'b0);
    m0_req_i = 1'b1; m0_addr_i = 32'h1000; m0_sel_i = 4'hF;
    m1_req_i = 1'b1; m1_addr_i = 32'h2000; m1_sel_i = 4'hF;
    ack_delay = 0; sl_rdata = 32'h0000_0055;
    ng = 0; rv0 = 0; rv1 = 0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      tick();
      if (m0_rvalid_o) rv0++;
      if (m1_rvalid_o) rv1++;
      if (m0_gnt_o) begin gseq[ng] = 1'b0; ng++; end
      else if (m1_gnt_o) begin gseq[ng] = 1'b1; ng++; end
    end
    m0_req_i = 1'b0;
    m1_req_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (m0_rvalid_o) rv0++;
      if (m1_rvalid_o) rv1++;
    end
    chk("rr_grants", ng, 4);
    if (ng == 4) begin
      chk("rr_g0", {31'h0, gseq[0]}, 32'h0);
      chk("rr_g1", {31'h0, gseq[1]}, 32'h1);
      chk("rr_g2", {31'h0, gseq[2]}, 32'h0);
      chk("rr_g3", {31'h0, gseq[3]}, 32'h1);
    end
    chk("rr_rv0", rv0, 2);
    chk("rr_rv1", rv1, 2);
    clear_masters();

    // ---- m1 store, 5 XFER cycles, inputs change after grant ----
    m1_req_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 32'h700;
    m1_wdata_i = 32'h5A5A5A5A; m1_sel_i = 4'b0011;
    ack_delay = 4; sl_rdata = 32'hFFFFFFFF;
    wait_gnt(ok);
    chk("st_gnt", {30'h0, m1_gnt_o, m0_gnt_o}, 32'h2);
    m1_req_i = 1'b0; m1_we_i = 1'b0; m1_addr_i = 32'hDEAD0000;
    m1_wdata_i = 32'h0; m1_sel_i = 4'hF;
    nx = 0; nbad = 0;
    for (int i = 0; i < 20 && s_req_o; i++) begin
      nx++;
      if (s_we_o !== 1'b1 || s_addr_o !== 32'h700 || s_wdata_o !== 32'h5A5A5A5A ||
          s_sel_o !== 4'b0011) nbad++;
      tick();
    end
    chk("st_xfer_cycles", nx, 5);
    chk("st_unstable", nbad, 0);
    rv0 = 0; rv1 = 0; rd = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      if (m1_rvalid_o) begin rv1++; rd = m_rdata_o; end
      if (m0_rvalid_o) rv0++;
      tick();
    end
    chk("st_rv1_count", rv1, 1);
    chk("st_rv0_count", rv0, 0);
    chk("st_rdata", rd, 32'h0);
    clear_masters();

    // ---- reset in the middle of XFER ----
    m0_req_i = 1'b1; m0_addr_i = 32'h900; m0_sel_i = 4'hF;
    ack_delay = 1000;
    wait_gnt(ok);
    chk("rx_gnt", {30'h0, m1_gnt_o, m0_gnt_o}, 32'h1);
    tick();
    tick();
    chk("rx_s_req_before", {31'h0, s_req_o}, 32'h1);
    m0_req_i = 1'b0;
    n_rst_i  = 1'b0;
    #1;
    chk("rx_s_req_async", {31'h0, s_req_o}, 32'h0);
    tick();
    n_rst_i = 1'b1;
    rv0 = 0; ng = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m0_rvalid_o || m1_rvalid_o) rv0++;
      if (m0_gnt_o || m1_gnt_o) ng++;
    end
    chk("rx_no_rvalid", rv0, 0);
    chk("rx_no_gnt", ng, 0);
    // priority must be back on m0 even though m0 won before the reset
    ack_delay = 0;
    m0_req_i = 1'b1; m0_addr_i = 32'hA0;
    m1_req_i = 1'b1; m1_addr_i = 32'hB0;
    wait_gnt(ok);
    chk("rx_prio_gnt", {30'h0, m1_gnt_o, m0_gnt_o}, 32'h1);
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    wait_rvalid(ok);
    chk("rx_prio_rvalid", {30'h0, m1_rvalid_o, m0_rvalid_o}, 32'h1);
    tick();
    clear_masters();

    // ---- slave never acks ----
    m0_req_i = 1'b1; m0_addr_i = 32'hA00; m0_sel_i = 4'hF;
    ack_delay = 1000; sl_rdata = 32'h77777777;
    wait_gnt(ok);
    chk("to_gnt", {30'h0, m1_gnt_o, m0_gnt_o}, 32'h1);
    m0_req_i = 1'b0;
`ifdef DBUS_TIMEOUT_EN
    nx = 0;
    for (int i = 0; i < 100 && s_req_o; i++) begin
      nx++;
      tick();
    end
    chk("to_xfer_cycles", nx, 16);
    wait_rvalid(ok);
    chk("to_rvalid", {30'h0, m1_rvalid_o, m0_rvalid_o}, 32'h1);
    chk("to_err", {31'h0, err_o}, 32'h1);
    chk("to_rdata", m_rdata_o, 32'h0);
    tick();
    chk("to_err_clear", {31'h0, err_o}, 32'h0);
`else
    nx = 0; rv0 = 0;
    for (int i = 0; i < 40; i++) begin
      if (s_req_o) nx++;
      if (m0_rvalid_o || m1_rvalid_o) rv0++;
      tick();
    end
    chk("nto_s_req_held", nx, 40);
    chk("nto_no_rvalid", rv0, 0);
    ack_delay = 0;
    wait_rvalid(ok);
    chk("nto_rvalid", {30'h0, m1_rvalid_o, m0_rvalid_o}, 32'h1);
    chk("nto_rdata", m_rdata_o, 32'h77777777);
    chk("nto_err", {31'h0, err_o}, 32'h0);
    tick();
`endif
    clear_masters();
    tick();

    chk("exclusive_gnt_rvalid", excl_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
